reaction_ctrl: RTL and testbench
================================

Name: reaction_ctrl

Overview:
Reaction-timer control FSM for the push-button front end.
- Start press → pseudo-random delay → stimulus LED on → reaction time counted in milliseconds until the stop press.
- Drives the select input of the downstream 2:1 display mux: disp_sel=0 shows the reaction time, disp_sel=1 shows the status/message source.
- Also supplies the reaction-time value to that mux.

Parameters:
TICK_DIV, 50000, clock cycles per 1 ms tick (50 MHz clock); must be ≥2.
DELAY_MIN_MS, 1000, minimum random delay in ms; must be ≥1.
DELAY_RAND_BITS, 11, LFSR bits added to the delay (adds 0..2047 ms); must be ≤16.
TIME_W, 14, width of react_ms; saturation value TIME_MAX = 9999.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  debounced single-cycle start pulse
stop  in  1  debounced single-cycle stop/react pulse
clear  in  1  single-cycle return-to-idle pulse
stim_led  out  1  stimulus LED
disp_sel  out  1  display mux select (0 = time, 1 = status)
react_ms  out  TIME_W  measured reaction time, ms
done  out  1  valid result held
cheat  out  1  stop pressed before the stimulus
best_ms  out  TIME_W  best time (optional feature)

Behaviour:
Interface:
- One clock, clk.
- Reset rst_n is asynchronous and active-low.
- All outputs are registered.

Reset values:
- state=IDLE, stim_led=0, disp_sel=1, react_ms=0, done=0, cheat=0, best_ms=TIME_MAX.
- Prescaler=0, LFSR=16'hACE1.

LFSR:
- 16-bit Fibonacci, taps 16,14,13,11.
- Advances every cycle in every state; never all-zero.

Prescaler:
- Counts 0..TICK_DIV-1 only in WAIT and RUN.
- tick is asserted for the one cycle when count==TICK_DIV-1.
- Cleared to 0 on entry to WAIT and to RUN.

Input priority: clear > stop > start > tick.

States:
- IDLE (disp_sel=1)
  - start → WAIT.
  - Loads delay_cnt = DELAY_MIN_MS + lfsr[DELAY_RAND_BITS-1:0]; clears react_ms, done and cheat.
- WAIT (stim_led=0, disp_sel=1)
  - Each tick decrements delay_cnt.
  - tick with delay_cnt==1 → RUN; stim_led=1 from the next cycle.
  - stop → CHEAT; cheat=1.
  - start is ignored.
- RUN (stim_led=1)
  - Each tick increments react_ms.
  - stop → DONE; react_ms is frozen. If stop and tick occur in the same cycle, there is no increment.
  - tick with react_ms==TIME_MAX-1 → react_ms=TIME_MAX, then DONE (timeout).
  - start is ignored.
- DONE (stim_led=0, done=1, disp_sel=0)
  - start → WAIT (new trial, same load as from IDLE).
- CHEAT (stim_led=0, cheat=1, disp_sel=1)
  - start → WAIT.

Clear and reset:
- clear in any state → IDLE next cycle; stim_led=0, done=0, cheat=0. react_ms is retained.
- rst_n low at any point, including mid-RUN, immediately forces all reset values.

Latency:
- stop sampled at edge N → done=1 and disp_sel=0 after edge N.
- react_ms is stable from the same edge.

Optional Feature:
REACTION_BEST_TIME_EN
- Defined:
  - On every RUN→DONE transition caused by stop, best_ms is updated to the new time if it is lower than the current best_ms.
  - Timeouts do not update best_ms.
  - clear does not reset best_ms; only rst_n does.
- Undefined: best_ms is tied to TIME_MAX; no comparator or register is built.

Decomposition:
- Package reaction_pkg:
  - state enum (IDLE, WAIT, RUN, DONE, CHEAT)
  - TIME_MAX=9999
  - LFSR_SEED=16'hACE1
  - LFSR tap constant
- Sub-module lfsr16: clk, rst_n, 16-bit state out, seeded from reaction_pkg.
- Prescaler and FSM stay in reaction_ctrl.

Test Plan:
Benches override TICK_DIV=4, DELAY_MIN_MS=3, DELAY_RAND_BITS=2.
1. Reset released, no inputs for 20 cycles → stim_led=0, disp_sel=1, react_ms=0, done=0, cheat=0, best_ms=9999.
2. start, then stop 2 ticks later (still in WAIT) → cheat=1, stim_led=0, disp_sel=1. Next start → WAIT with cheat=0.
3. start, wait for stim_led=1, stop after exactly 10 ticks → react_ms=10, done=1, disp_sel=0, stim_led=0. With the macro defined, best_ms=10.
4. stop asserted in the same cycle as the 7th RUN tick → react_ms=6 (stop wins, no increment).
5. RUN with no stop → react_ms saturates at 9999, done=1; best_ms unchanged.
6. clear mid-RUN, and rst_n pulsed low mid-WAIT → IDLE with stim_led=0 next cycle (clear) and immediately (rst_n); a start during RUN has no effect.

Source files
------------

// File: rtl/reaction_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : reaction_pkg                                                 |
// | Purpose : Shared types and constants for the reaction-timer controller:|
// |           FSM state encoding, result saturation value, LFSR seed/taps. |
// | Ports   : none (package)                                               |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3,
    CHEAT = 3'd4
  } state_e;

  // Largest displayable reaction time (four decimal digits).
  localparam int TIME_MAX = 9999;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Feedback taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage : reaction_pkg
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : lfsr16                                                       |
// | Purpose : Free-running 16-bit Fibonacci LFSR (maximal length), advances|
// |           every clock; source of the pseudo-random wait delay.         |
// | Ports   : clk      in  system clock                                    |
// |           rst_n    in  asynchronous active-low reset (loads seed)      |
// |           state_o  out 16  current LFSR state                          |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module lfsr16
  import reaction_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] state_o
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  // Maximal-length polynomial with a non-zero seed never reaches all-zero.
  assign state_d = {state_q[14:0], ^(state_q & LFSR_TAPS)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LFSR_SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule : lfsr16
`default_nettype wire

// File: rtl/reaction_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : reaction_ctrl                                                |
// | Purpose : Reaction-timer control FSM. start -> random delay -> LED on  |
// |           -> count ms until stop. Drives the display mux select and    |
// |           the measured time. Optional best-time tracking is built when |
// |           the macro REACTION_BEST_TIME_EN is defined.                  |
// | Ports   : clk, rst_n             clock, async active-low reset         |
// |           start_i/stop_i/clear_i single-cycle control pulses           |
// |           stim_led_o             stimulus LED                          |
// |           disp_sel_o             mux select (0 time, 1 status)         |
// |           react_ms_o             measured reaction time in ms          |
// |           done_o / cheat_o       valid result / early stop flags       |
// |           best_ms_o              best stop-terminated time             |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module reaction_ctrl
  import reaction_pkg::*;
#(
  parameter int TICK_DIV        = 50000,
  parameter int DELAY_MIN_MS    = 1000,
  parameter int DELAY_RAND_BITS = 11,
  parameter int TIME_W          = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              clear_i,
  output logic              stim_led_o,
  output logic              disp_sel_o,
  output logic [TIME_W-1:0] react_ms_o,
  output logic              done_o,
  output logic              cheat_o,
  output logic [TIME_W-1:0] best_ms_o
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DELAY_MIN_MS + (1 << DELAY_RAND_BITS)) + 1;

  logic [15:0]       w_lfsr;
  logic              w_lfsr_unused;
  logic              w_tick;
  logic [DW-1:0]     w_delay_load;

  state_e            state_q, state_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [DW-1:0]     delay_q, delay_d;
  logic [TIME_W-1:0] react_q, react_d;
  logic              stim_q, stim_d;
  logic              sel_q, sel_d;
  logic              done_q, done_d;
  logic              cheat_q, cheat_d;

  lfsr16 u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .state_o (w_lfsr)
  );

  // Only the low bits feed the delay; the rest still clock for sequence quality.
  assign w_lfsr_unused = ^w_lfsr;

  assign w_delay_load = DW'(DELAY_MIN_MS) + DW'(w_lfsr[DELAY_RAND_BITS-1:0]);

  assign w_tick = ((state_q == WAIT) || (state_q == RUN)) &&
                  (presc_q == PW'(TICK_DIV - 1));

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    delay_d = delay_q;
    react_d = react_q;
    stim_d  = stim_q;
    sel_d   = sel_q;
    done_d  = done_q;
    cheat_d = cheat_q;

    if ((state_q == WAIT) || (state_q == RUN)) begin
      presc_d = w_tick ? '0 : presc_q + PW'(1);
    end

    if (clear_i) begin
      // Clear keeps the last measured time visible on the mux input.
      state_d = IDLE;
      presc_d = '0;
      stim_d  = 1'b0;
      sel_d   = 1'b1;
      done_d  = 1'b0;
      cheat_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE, CHEAT: begin
          if (start_i) begin
            state_d = WAIT;
            presc_d = '0;
            delay_d = w_delay_load;
            react_d = '0;
            stim_d  = 1'b0;
            sel_d   = 1'b1;
            done_d  = 1'b0;
            cheat_d = 1'b0;
          end
        end
        WAIT: begin
          if (stop_i) begin
            state_d = CHEAT;
            cheat_d = 1'b1;
            stim_d  = 1'b0;
            sel_d   = 1'b1;
          end else if (w_tick) begin
            if (delay_q == DW'(1)) begin
              state_d = RUN;
              presc_d = '0;
              stim_d  = 1'b1;
            end else begin
              delay_d = delay_q - DW'(1);
            end
          end
        end
        RUN: begin
          // A stop coinciding with a tick freezes the time without the increment.
          if (stop_i) begin
            state_d = DONE;
            stim_d  = 1'b0;
            sel_d   = 1'b0;
            done_d  = 1'b1;
          end else if (w_tick) begin
            react_d = react_q + TIME_W'(1);
            if (react_q == TIME_W'(TIME_MAX - 1)) begin
              state_d = DONE;
              stim_d  = 1'b0;
              sel_d   = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      delay_q <= '0;
      react_q <= '0;
      stim_q  <= 1'b0;
      sel_q   <= 1'b1;
      done_q  <= 1'b0;
      cheat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      delay_q <= delay_d;
      react_q <= react_d;
      stim_q  <= stim_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
      cheat_q <= cheat_d;
    end
  end

  assign stim_led_o = stim_q;
  assign disp_sel_o = sel_q;
  assign react_ms_o = react_q;
  assign done_o     = done_q;
  assign cheat_o    = cheat_q;

`ifdef REACTION_BEST_TIME_EN
  logic [TIME_W-1:0] best_q, best_d;

  // Only stop-terminated runs qualify; timeouts leave the record untouched.
  always_comb begin
    best_d = best_q;
    if ((state_q == RUN) && !clear_i && stop_i && (react_q < best_q)) begin
      best_d = react_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_q <= TIME_W'(TIME_MAX);
    end else begin
      best_q <= best_d;
    end
  end

  assign best_ms_o = best_q;
`else
  assign best_ms_o = TIME_W'(TIME_MAX);
`endif

endmodule : reaction_ctrl
`default_nettype wire

// File: tb/tb_reaction_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_reaction_ctrl                                             |
// | Purpose : Self-checking bench for reaction_ctrl with small timing      |
// |           parameters; honours REACTION_BEST_TIME_EN when defined.      |
// | Ports   : none                                                         |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_reaction_ctrl;

  localparam int TB_TICK = 4;
  localparam int TB_MIN  = 3;
  localparam int TB_RB   = 2;
  localparam int TB_W    = 14;
  localparam int TB_TMAX = 9999;

  logic            clk;
  logic            rst_n;
  logic            start_i;
  logic            stop_i;
  logic            clear_i;
  logic            stim_led_o;
  logic            disp_sel_o;
  logic [TB_W-1:0] react_ms_o;
  logic            done_o;
  logic            cheat_o;
  logic [TB_W-1:0] best_ms_o;

  int total;
  int bad;
  int exp_best;
  int lfsr_m;

  reaction_ctrl #(
    .TICK_DIV        (TB_TICK),
    .DELAY_MIN_MS    (TB_MIN),
    .DELAY_RAND_BITS (TB_RB),
    .TIME_W          (TB_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .clear_i    (clear_i),
    .stim_led_o (stim_led_o),
    .disp_sel_o (disp_sel_o),
    .react_ms_o (react_ms_o),
    .done_o     (done_o),
    .cheat_o    (cheat_o),
    .best_ms_o  (best_ms_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference pseudo-random source: x^16+x^14+x^13+x^11+1, shifted toward the MSB.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_m = 'hACE1;
    end else begin
      lfsr_m = ((lfsr_m << 1) | (((lfsr_m >> 15) ^ (lfsr_m >> 13) ^
                (lfsr_m >> 12) ^ (lfsr_m >> 10)) & 1)) & 'hFFFF;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse start; returns the delay in ms the design should load.
  task automatic press_start(output int d);
    d = TB_MIN + (lfsr_m % (1 << TB_RB));
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
  endtask

  task automatic wait_stim(input int d);
    step(TB_TICK * d - 1);
    check("stim_before_delay", stim_led_o, 1'b0);
    step(1);
    check("stim_on_after_delay", stim_led_o, 1'b1);
  endtask

  // Stop sampled on RUN cycle c (cycle 1 = first cycle with the LED lit);
  // 'used' RUN cycles have already been stepped by the caller.
  task automatic run_stop(input int c, input int used);
    int exp_t;
    step(c - 1 - used);
    stop_i = 1'b1;
    step(1);
    stop_i = 1'b0;
    exp_t = (c - 1) / TB_TICK;
`ifdef REACTION_BEST_TIME_EN
    if (exp_t < exp_best) exp_best = exp_t;
`endif
    check("stop_react_ms", react_ms_o, exp_t);
    check("stop_done", done_o, 1'b1);
    check("stop_disp_sel", disp_sel_o, 1'b0);
    check("stop_stim_off", stim_led_o, 1'b0);
    check("stop_best_ms", best_ms_o, exp_best);
  endtask

  initial begin
    int d;
    int c;
    int cnt;
    int hold;
    total    = 0;
    bad      = 0;
    exp_best = TB_TMAX;
    rst_n    = 1'b0;
    start_i  = 1'b0;
    stop_i   = 1'b0;
    clear_i  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset.
    step(20);
    check("rst_stim", stim_led_o, 1'b0);
    check("rst_disp_sel", disp_sel_o, 1'b1);
    check("rst_react", react_ms_o, 0);
    check("rst_done", done_o, 1'b0);
    check("rst_cheat", cheat_o, 1'b0);
    check("rst_best", best_ms_o, TB_TMAX);

    // Early stop two ticks into the wait.
    press_start(d);
    step(2 * TB_TICK);
    stop_i = 1'b1;
    step(1);
    stop_i = 1'b0;
    check("cheat_flag", cheat_o, 1'b1);
    check("cheat_stim", stim_led_o, 1'b0);
    check("cheat_disp_sel", disp_sel_o, 1'b1);
    check("cheat_done", done_o, 1'b0);

    // Restart from CHEAT, then stop exactly after ten ticks.
    press_start(d);
    check("restart_cheat_clr", cheat_o, 1'b0);
    wait_stim(d);
    run_stop(10 * TB_TICK + 1, 0);

    // Stop coinciding with the 7th tick: no increment.
    press_start(d);
    check("newtrial_done_clr", done_o, 1'b0);
    check("newtrial_react_clr", react_ms_o, 0);
    wait_stim(d);
    run_stop(7 * TB_TICK, 0);

    // Randomised trials with random reaction lengths and idle gaps.
    for (int t = 0; t < 6; t++) begin
      press_start(d);
      wait_stim(d);
      c = $urandom_range(1, 60);
      run_stop(c, 0);
      hold = react_ms_o;
      step($urandom_range(0, 7));
      check("done_react_stable", react_ms_o, hold);
    end

    // start during RUN is ignored.
    press_start(d);
    wait_stim(d);
    step(5);
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
    check("run_start_ignored_stim", stim_led_o, 1'b1);
    check("run_start_ignored_done", done_o, 1'b0);
    run_stop(23, 6);

    // Saturation with no stop.
    press_start(d);
    wait_stim(d);
    cnt = 0;
    while (done_o !== 1'b1 && cnt < 40100) begin
      step(1);
      cnt++;
    end
    check("sat_cycles", cnt, TB_TICK * TB_TMAX);
    check("sat_react", react_ms_o, TB_TMAX);
    check("sat_done", done_o, 1'b1);
    check("sat_best_unchanged", best_ms_o, exp_best);

    // clear mid-RUN (off a tick cycle): back to IDLE, time retained.
    press_start(d);
    wait_stim(d);
    step(9);
    clear_i = 1'b1;
    step(1);
    clear_i = 1'b0;
    check("clear_stim", stim_led_o, 1'b0);
    check("clear_done", done_o, 1'b0);
    check("clear_cheat", cheat_o, 1'b0);
    check("clear_disp_sel", disp_sel_o, 1'b1);
    check("clear_react_kept", react_ms_o, 2);
    check("clear_best_kept", best_ms_o, exp_best);

    // Asynchronous reset in the middle of WAIT.
    press_start(d);
    check("start_from_idle_react", react_ms_o, 0);
    step(TB_TICK + 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_stim", stim_led_o, 1'b0);
    check("async_rst_disp_sel", disp_sel_o, 1'b1);
    check("async_rst_react", react_ms_o, 0);
    check("async_rst_best", best_ms_o, TB_TMAX);
    exp_best = TB_TMAX;
    step(2);
    rst_n = 1'b1;
    step(3);
    check("post_rst_stim", stim_led_o, 1'b0);
    check("post_rst_done", done_o, 1'b0);

    // A full trial after reset to confirm the seed restart.
    press_start(d);
    wait_stim(d);
    run_stop($urandom_range(1, 40), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_reaction_ctrl
`default_nettype wire
